aes_sub_shift: RTL
==================

Name: aes_sub_shift

Overview:
- Iterative AES SubBytes + ShiftRows stage; sits directly upstream of the registered MixColumns stage and feeds it a 128-bit state.
- Accepts one state via valid/ready, substitutes LANES bytes per cycle through LANES S-box instances, then presents the ShiftRows-permuted result until the consumer takes it.
- Trades throughput for S-box area; LANES selects the trade-off.

Parameters:
- LANES, 4, S-box instances and bytes substituted per cycle; legal values 4, 8, 16; N = 16/LANES substitution cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_state is valid
- in_ready  out  1  block can accept in_state this cycle
- in_state  in  128  AES state, column-major; [127:120]=row0/col0, [119:112]=row1/col0, …, [7:0]=row3/col3
- out_valid  out  1  out_state holds a finished result
- out_ready  in  1  consumer takes out_state this cycle
- out_state  out  128  ShiftRows(SubBytes(in_state)), same byte ordering as in_state
- busy  out  1  high in SUB or DONE

Behaviour:
- Reset (async assert, sync-safe release): FSM=IDLE, count=0, state register=0, out_valid=0, out_state=0, busy=0, in_ready=1 once rst_n is high. Reset mid-operation discards the in-flight state; no partial output.
- FSM states: IDLE, SUB, DONE.
- IDLE: in_ready=1. On in_valid, load in_state into the working register, count=0, go to SUB.
- SUB: in_ready=0. Each edge replaces bytes [count*LANES .. count*LANES+LANES-1] (byte 0 = [127:120]) with their S-box values and increments count. On the edge where count==N-1, go to DONE. For LANES=16, SUB lasts exactly one cycle.
- DONE: out_valid=1. out_state is combinational ShiftRows of the working register, so it is stable while in DONE.
  - Byte mapping: out(row r, col c) = sub(row r, col (c+r) mod 4).
- Handshakes:
  - Transfer out when out_valid && out_ready.
  - in_ready = IDLE || (DONE && out_ready).
  - DONE with out_ready=1, in_valid=1: output transfers and the new state loads on the same edge; go to SUB with no bubble.
  - DONE with out_ready=1, in_valid=0: go to IDLE.
  - DONE with out_ready=0: hold; out_state must not change and in_valid is ignored.
- Latency: exactly N edges from the accept edge to out_valid=1. Sustained throughput is one state per N+1 cycles with a backlogged source; a new state accepted on the handshake edge overlaps the output cycle.
- in_state is sampled only on the accept edge; later changes have no effect.
- count width is clog2(N) with a minimum of 1; it never wraps past N-1.
- S-box follows FIPS-197 exactly; no masking and no unused lanes.

Decomposition:
- Shared package aes_pkg:
  - state type (16×8 bit)
  - N_BYTES=16
  - S-box constant table
  - shift_rows index function, reused by the future inverse stage
  - FSM state enum
- Sub-module aes_sbox: 8-bit in, 8-bit out, purely combinational table lookup; instantiated LANES times.

Test Plan:
- LANES=4, FIPS-197 App. B round 1: in_state=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1 → out_valid 4 cycles after accept, out_state=d4bf5d30e0b452aeb84111f11e2798e5, busy high throughout.
- All-zero input → out_state=6363…63 (16 bytes). Input 53 replicated in all bytes → ed replicated. Repeat for LANES=8 (latency 2) and LANES=16 (latency 1).
- Backpressure: hold out_ready=0 for 10 cycles in DONE while changing in_state/in_valid → out_state constant, in_ready=0, no new load. Then release → single transfer.
- Back-to-back: stream 3 App. B states with in_valid and out_ready held high → new state accepted on each output edge, no dropped or duplicated outputs, period 5 cycles for LANES=4.
- Reset mid-SUB: assert rst_n=0 asynchronously after 2 SUB cycles → out_valid=0, out_state=0, FSM=IDLE immediately. Next accepted input yields a correct result.
- Idle inputs: in_valid=0 and random in_state for 20 cycles → out_valid stays 0, busy stays 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: state layout, S-box table, ShiftRows indexing.
package aes_pkg;

    localparam int N_BYTES = 16;

    // Byte 0 is the most significant byte; byte k sits at row k%4, col k/4.
    typedef logic [0:N_BYTES-1][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Source byte for output byte k: row r keeps, column rotates left by r.
    function automatic logic [3:0] shift_rows_idx(logic [3:0] k);
        logic [1:0] r;
        logic [1:0] c;
        r = k[1:0];
        c = k[3:2] + r;
        return {c, r};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 S-box lookup, one byte per instance.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_sub_shift.sv
// Iterative SubBytes + ShiftRows stage, LANES bytes substituted per cycle.
module aes_sub_shift
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int N  = N_BYTES / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    fsm_t          fsm;
    logic [CW-1:0] count;
    state_t        st;
    state_t        sub_next;
    state_t        sr;
    logic [3:0]    base;
    logic          load;

    logic [7:0] sb_in  [LANES];
    logic [7:0] sb_out [LANES];

    assign base = 4'(32'(count) * LANES);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign sb_in[i] = st[base + 4'(i)];
        aes_sbox u_sbox (
            .din  (sb_in[i]),
            .dout (sb_out[i])
        );
    end

    always_comb begin
        sub_next = st;
        for (int i = 0; i < LANES; i++) begin
            sub_next[base + 4'(i)] = sb_out[i];
        end
    end

    always_comb begin
        sr = '0;
        for (int k = 0; k < N_BYTES; k++) begin
            sr[k] = st[shift_rows_idx(4'(k))];
        end
    end

    assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign out_state = sr;
    assign load      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm   <= IDLE;
            count <= '0;
            st    <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (load) begin
                        st    <= in_state;
                        count <= '0;
                        fsm   <= SUB;
                    end
                end
                SUB: begin
                    st <= sub_next;
                    if (count == CW'(N - 1)) begin
                        count <= '0;
                        fsm   <= DONE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    // Output and next input share the handshake edge.
                    if (out_ready) begin
                        if (in_valid) begin
                            st    <= in_state;
                            count <= '0;
                            fsm   <= SUB;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                default: begin
                    fsm   <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
